// File: rtl/mastermind_scorer.sv
// Mastermind scoring engine: serially scores one guess against the secret code (red, then white)
// and tracks guess count, win and game-over for the current game.
module mastermind_scorer #(
    parameter int unsigned PEGS        = 4,
    parameter int unsigned COLOR_W     = 3,
    parameter int unsigned MAX_GUESSES = 8,
    localparam int unsigned CNT_W      = $clog2(PEGS + 1),
    localparam int unsigned GC_W       = $clog2(MAX_GUESSES + 1)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      clear,
    input  logic                      start,
    input  logic [PEGS*COLOR_W-1:0]   code,
    input  logic [PEGS*COLOR_W-1:0]   guess,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          red,
    output logic [CNT_W-1:0]          white,
    output logic [GC_W-1:0]           guess_count,
    output logic                      solved,
    output logic                      game_over
);

    localparam int unsigned IDX_W = $clog2(PEGS);

    typedef enum logic [1:0] {StIdle, StRed, StWhite, StDone} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [PEGS*COLOR_W-1:0]   code_q, code_d;
    logic [PEGS*COLOR_W-1:0]   guess_q, guess_d;
    logic [PEGS-1:0]           code_used_q, code_used_d;
    logic [PEGS-1:0]           guess_used_q, guess_used_d;
    logic [CNT_W-1:0]          wred_q, wred_d;
    logic [CNT_W-1:0]          wwhite_q, wwhite_d;
    logic [CNT_W-1:0]          red_q, red_d;
    logic [CNT_W-1:0]          white_q, white_d;
    logic                      done_q, done_d;
    logic [GC_W-1:0]           gc_q, gc_d;
    logic                      solved_q, solved_d;
    logic                      over_q, over_d;
    logic                      found;
    logic                      last_idx;

    assign last_idx = (idx_q == IDX_W'(PEGS - 1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        code_d       = code_q;
        guess_d      = guess_q;
        code_used_d  = code_used_q;
        guess_used_d = guess_used_q;
        wred_d       = wred_q;
        wwhite_d     = wwhite_q;
        red_d        = red_q;
        white_d      = white_q;
        done_d       = 1'b0;
        gc_d         = gc_q;
        solved_d     = solved_q;
        over_d       = over_q;
        found        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !over_q) begin
                    code_d       = code;
                    guess_d      = guess;
                    code_used_d  = '0;
                    guess_used_d = '0;
                    wred_d       = '0;
                    wwhite_d     = '0;
                    idx_d        = '0;
                    state_d      = StRed;
                end
            end
            StRed: begin
                if (code_q[idx_q*COLOR_W +: COLOR_W] == guess_q[idx_q*COLOR_W +: COLOR_W]) begin
                    wred_d              = wred_q + CNT_W'(1);
                    code_used_d[idx_q]  = 1'b1;
                    guess_used_d[idx_q] = 1'b1;
                end
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                if (last_idx) state_d = StWhite;
            end
            StWhite: begin
                // Lowest unused matching code peg wins, so each code peg is consumed once.
                if (!guess_used_q[idx_q]) begin
                    for (int j = 0; j < int'(PEGS); j++) begin
                        if (!found && !code_used_q[j] &&
                            code_q[j*COLOR_W +: COLOR_W] == guess_q[idx_q*COLOR_W +: COLOR_W]) begin
                            found          = 1'b1;
                            code_used_d[j] = 1'b1;
                        end
                    end
                end
                if (found) wwhite_d = wwhite_q + CNT_W'(1);
                idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
                if (last_idx) state_d = StDone;
            end
            StDone: begin
                red_d    = wred_q;
                white_d  = wwhite_q;
                done_d   = 1'b1;
                gc_d     = (gc_q < GC_W'(MAX_GUESSES)) ? gc_q + GC_W'(1) : gc_q;
                solved_d = solved_q | (wred_q == CNT_W'(PEGS));
                over_d   = solved_d | (gc_d == GC_W'(MAX_GUESSES));
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d  = StIdle;
            idx_d    = '0;
            red_d    = '0;
            white_d  = '0;
            done_d   = 1'b0;
            gc_d     = '0;
            solved_d = 1'b0;
            over_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            code_q       <= '0;
            guess_q      <= '0;
            code_used_q  <= '0;
            guess_used_q <= '0;
            wred_q       <= '0;
            wwhite_q     <= '0;
            red_q        <= '0;
            white_q      <= '0;
            done_q       <= 1'b0;
            gc_q         <= '0;
            solved_q     <= 1'b0;
            over_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            guess_q      <= guess_d;
            code_used_q  <= code_used_d;
            guess_used_q <= guess_used_d;
            wred_q       <= wred_d;
            wwhite_q     <= wwhite_d;
            red_q        <= red_d;
            white_q      <= white_d;
            done_q       <= done_d;
            gc_q         <= gc_d;
            solved_q     <= solved_d;
            over_q       <= over_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign red         = red_q;
    assign white       = white_q;
    assign guess_count = gc_q;
    assign solved      = solved_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_mastermind_scorer.sv
// Bench for mastermind_scorer: colour-count scoring model with a latency counter, checked every
// cycle, plus directed games with hand-computed scores.
module tb_mastermind_scorer;

    localparam int P  = 4;
    localparam int CW = 3;
    localparam int MG = 8;

    logic        clock, resetn, clear, start;
    logic [11:0] code, guess;
    logic        busy, done, solved, game_over;
    logic [2:0]  red, white;
    logic [3:0]  guess_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    mastermind_scorer #(
        .PEGS        (P),
        .COLOR_W     (CW),
        .MAX_GUESSES (MG)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .clear       (clear),
        .start       (start),
        .code        (code),
        .guess       (guess),
        .busy        (busy),
        .done        (done),
        .red         (red),
        .white       (white),
        .guess_count (guess_count),
        .solved      (solved),
        .game_over   (game_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Red = exact positions; white = per-colour min of the leftover counts.
    function automatic void model_score(input logic [11:0] c, input logic [11:0] g,
                                        output int r, output int w);
        int cc[8];
        int gg[8];
        logic [2:0] cp, gp;
        r = 0;
        w = 0;
        for (int k = 0; k < 8; k++) begin cc[k] = 0; gg[k] = 0; end
        for (int i = 0; i < P; i++) begin
            cp = c[i*CW +: CW];
            gp = g[i*CW +: CW];
            if (cp == gp) r++;
            else begin cc[cp]++; gg[gp]++; end
        end
        for (int k = 0; k < 8; k++) w += (cc[k] < gg[k]) ? cc[k] : gg[k];
    endfunction

    int left, p_red, p_white;
    int m_red, m_white, m_gc;
    bit m_done, m_solved, m_over;

    always @(posedge clock or negedge resetn) begin
        if (!resetn || clear) begin
            left = 0; m_done = 0; m_red = 0; m_white = 0; m_gc = 0; m_solved = 0; m_over = 0;
        end else begin
            m_done = 0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    m_done   = 1;
                    m_red    = p_red;
                    m_white  = p_white;
                    m_gc     = (m_gc < MG) ? m_gc + 1 : m_gc;
                    m_solved = m_solved || (p_red == P);
                    m_over   = m_solved || (m_gc == MG);
                end
            end else if (start && !m_over) begin
                model_score(code, guess, p_red, p_white);
                left = 2 * P + 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, (left > 0));
            check("done", done, m_done);
            check("red", red, m_red);
            check("white", white, m_white);
            check("guess_count", guess_count, m_gc);
            check("solved", solved, m_solved);
            check("game_over", game_over, m_over);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_done(output bit seen, output int n);
        seen = 0;
        n    = 1;
        while (!seen && n <= 30) begin
            if (done) seen = 1;
            else begin tick(); n++; end
        end
        check("done_seen", seen, 1);
    endtask

    task automatic score_guess(input logic [11:0] c, input logic [11:0] g, input int er,
                               input int ew, input int egc, input int esol, input int eover);
        bit seen;
        int n;
        code  = c;
        guess = g;
        start = 1;
        tick();
        start = 0;
        wait_done(seen, n);
        if (seen) begin
            check("latency", n, 10);
            check("lit_red", red, er);
            check("lit_white", white, ew);
            check("lit_gc", guess_count, egc);
            check("lit_solved", solved, esol);
            check("lit_over", game_over, eover);
        end
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick();
            check({name, "_busy"}, busy, 0);
            check({name, "_done"}, done, 0);
        end
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
        check("clr_gc", guess_count, 0);
        check("clr_over", game_over, 0);
        check("clr_red", red, 0);
    endtask

    initial begin
        bit seen;
        int n;
        resetn = 0; clear = 0; start = 0; code = '0; guess = '0;
        tick();
        chk_en = 1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_red", red, 0);
        check("rst_gc", guess_count, 0);
        resetn = 1;
        tick();

        score_guess(12'o4321, 12'o5231, 1, 2, 1, 0, 0);
        score_guess(12'o2211, 12'o1121, 1, 2, 2, 0, 0);
        score_guess(12'o3333, 12'o0003, 1, 0, 3, 0, 0);
        score_guess(12'o7070, 12'o7070, 4, 0, 4, 1, 1);
        start = 1;
        expect_idle("after_win", 3);
        start = 0;
        do_clear();

        for (int i = 0; i < MG; i++) begin
            if (i % 2 == 0) score_guess(12'o1234, 12'o4321, 0, 4, i + 1, 0, (i == MG - 1));
            else            score_guess(12'o1234, 12'o1111, 1, 0, i + 1, 0, (i == MG - 1));
        end
        start = 1;
        expect_idle("ninth", 3);
        start = 0;
        do_clear();
        score_guess(12'o1234, 12'o4321, 0, 4, 1, 0, 0);

        // Second start during RED with a winning guess must not be seen.
        code = 12'o4321; guess = 12'o5231; start = 1;
        tick();
        start = 0;
        tick();
        start = 1; guess = 12'o4321;
        tick();
        start = 0; guess = 12'o5231;
        wait_done(seen, n);
        if (seen) begin
            check("red_in_red", red, 1);
            check("white_in_red", white, 2);
        end

        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        clear = 1;
        tick();
        clear = 0;
        check("clr_white_busy", busy, 0);
        expect_idle("post_clear", 12);

        score_guess(12'o0123, 12'o0132, 2, 2, 1, 0, 0);
        start = 1;
        tick();
        start = 0;
        repeat (5) tick();
        #2 resetn = 0;
        #1;
        check("async_busy", busy, 0);
        check("async_red", red, 0);
        check("async_white", white, 0);
        check("async_gc", guess_count, 0);
        tick();
        resetn = 1;
        expect_idle("post_reset", 12);
        score_guess(12'o6655, 12'o5566, 0, 4, 1, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
